// File: rtl/regfile_pkg.sv
// Shared types and dimensions for the 4x2-bit register-file controller.
// State encoding and bank geometry live here so every file agrees on them.
package regfile_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/regfile_ctrl_decoder.sv
// Combinational 2-bit address to 4-bit one-hot decoder with enable.
// A disabled or unknown address yields an all-zero select.
module addr_decoder_2to4
    import regfile_pkg::*;
(
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DEPTH-1:0]  onehot
);

    // Address to one-hot row select, gated by enable
    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            case (addr)
                2'd0:    onehot = 4'b0001;
                2'd1:    onehot = 4'b0010;
                2'd2:    onehot = 4'b0100;
                2'd3:    onehot = 4'b1000;
                default: onehot = 4'b0000;
            endcase
        end else begin
            onehot = 4'b0000;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Command/response controller for a 4x2-bit register bank: single-cycle
// write strobes, dual-port read capture and a held read response.
module regfile_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic              Cmd_Write,
    input  logic [ADDR_W-1:0] Cmd_Waddr,
    input  logic [DATA_W-1:0] Cmd_Wdata,
    input  logic [ADDR_W-1:0] Cmd_Raddr1,
    input  logic [ADDR_W-1:0] Cmd_Raddr2,
    output logic [DEPTH-1:0]  Write_Select,
    output logic [DATA_W-1:0] Write_Data,
    output logic [DEPTH-1:0]  Read_Select_1,
    output logic [DEPTH-1:0]  Read_Select_2,
    input  logic [DATA_W-1:0] Read_Data_1,
    input  logic [DATA_W-1:0] Read_Data_2,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [DATA_W-1:0] Rsp_Data1,
    output logic [DATA_W-1:0] Rsp_Data2
);

    state_e              state_r, next_state_s;
    logic                accept_s;
    logic [ADDR_W-1:0]   waddr_r, raddr1_r, raddr2_r;
    logic [ADDR_W-1:0]   waddr_s, raddr1_s, raddr2_s;
    logic [DEPTH-1:0]    wsel_s, rsel1_s, rsel2_s;
    logic [DEPTH-1:0]    wsel_r, rsel1_r, rsel2_r;
    logic [DATA_W-1:0]   wdata_r, rsp_data1_r, rsp_data2_r;
    logic                rsp_valid_r;

    assign Cmd_Ready = (state_r == IDLE) && !reset;
    assign accept_s  = Cmd_Valid && Cmd_Ready;

    // Next-state logic for the command FSM
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = Cmd_Write ? WRITE : READ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITE: next_state_s = IDLE;
            READ:  next_state_s = RESP;
            RESP: begin
                if (Rsp_Ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Selects are registered, so decode the address that the next state will use
    always_comb begin
        waddr_s  = waddr_r;
        raddr1_s = raddr1_r;
        raddr2_s = raddr2_r;
        if (accept_s) begin
            waddr_s  = Cmd_Waddr;
            raddr1_s = Cmd_Raddr1;
            raddr2_s = Cmd_Raddr2;
        end else begin
            waddr_s  = waddr_r;
            raddr1_s = raddr1_r;
            raddr2_s = raddr2_r;
        end
    end

    addr_decoder_2to4 u_wdec  (.en(next_state_s == WRITE), .addr(waddr_s),  .onehot(wsel_s));
    addr_decoder_2to4 u_rdec1 (.en(next_state_s == READ),  .addr(raddr1_s), .onehot(rsel1_s));
    addr_decoder_2to4 u_rdec2 (.en(next_state_s == READ),  .addr(raddr2_s), .onehot(rsel2_s));

    // State, command latches, registered strobes and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            waddr_r     <= 2'b00;
            raddr1_r    <= 2'b00;
            raddr2_r    <= 2'b00;
            wdata_r     <= 2'b00;
            wsel_r      <= 4'b0000;
            rsel1_r     <= 4'b0000;
            rsel2_r     <= 4'b0000;
            rsp_valid_r <= 1'b0;
            rsp_data1_r <= 2'b00;
            rsp_data2_r <= 2'b00;
        end else begin
            state_r     <= next_state_s;
            waddr_r     <= waddr_s;
            raddr1_r    <= raddr1_s;
            raddr2_r    <= raddr2_s;
            wsel_r      <= wsel_s;
            rsel1_r     <= rsel1_s;
            rsel2_r     <= rsel2_s;
            rsp_valid_r <= (next_state_s == RESP);
            if (accept_s && Cmd_Write) begin
                wdata_r <= Cmd_Wdata;
            end
            // Bank read buses are valid during the single READ cycle only
            if (state_r == READ) begin
                rsp_data1_r <= Read_Data_1;
                rsp_data2_r <= Read_Data_2;
            end
        end
    end

    assign Write_Select  = wsel_r;
    assign Write_Data    = wdata_r;
    assign Read_Select_1 = rsel1_r;
    assign Read_Select_2 = rsel2_r;
    assign Rsp_Valid     = rsp_valid_r;
    assign Rsp_Data1     = rsp_data1_r;
    assign Rsp_Data2     = rsp_data2_r;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural 4x2-bit bank attached.
module tb_regfile_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       Cmd_Valid, Cmd_Ready, Cmd_Write;
    logic [1:0] Cmd_Waddr, Cmd_Wdata, Cmd_Raddr1, Cmd_Raddr2;
    logic [3:0] Write_Select, Read_Select_1, Read_Select_2;
    logic [1:0] Write_Data, Read_Data_1, Read_Data_2;
    logic       Rsp_Valid, Rsp_Ready;
    logic [1:0] Rsp_Data1, Rsp_Data2;

    logic [1:0] bank [4];
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk(clk), .reset(reset),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Write(Cmd_Write),
        .Cmd_Waddr(Cmd_Waddr), .Cmd_Wdata(Cmd_Wdata),
        .Cmd_Raddr1(Cmd_Raddr1), .Cmd_Raddr2(Cmd_Raddr2),
        .Write_Select(Write_Select), .Write_Data(Write_Data),
        .Read_Select_1(Read_Select_1), .Read_Select_2(Read_Select_2),
        .Read_Data_1(Read_Data_1), .Read_Data_2(Read_Data_2),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
        .Rsp_Data1(Rsp_Data1), .Rsp_Data2(Rsp_Data2)
    );

    // Bank model: strobed row write, unselected rows read as zero
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (Write_Select[i]) bank[i] <= Write_Data;
        end
    end

    always_comb begin
        Read_Data_1 = 2'b00;
        Read_Data_2 = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (Read_Select_1[i]) Read_Data_1 = Read_Data_1 | bank[i];
            if (Read_Select_2[i]) Read_Data_2 = Read_Data_2 | bank[i];
        end
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] a);
        logic [3:0] v;
        v = 4'b0001 << a;
        return v;
    endfunction

    task automatic do_write(input logic [1:0] a, input logic [1:0] d);
        Cmd_Valid = 1'b1; Cmd_Write = 1'b1; Cmd_Waddr = a; Cmd_Wdata = d;
        check_eq("wr_ready", {7'd0, Cmd_Ready}, 8'd1);
        tick();
        Cmd_Valid = 1'b0; Cmd_Waddr = ~a; Cmd_Wdata = ~d;
        check_eq("wr_sel", {4'd0, Write_Select}, {4'd0, onehot(a)});
        check_eq("wr_data", {6'd0, Write_Data}, {6'd0, d});
        check_eq("wr_busy", {7'd0, Cmd_Ready}, 8'd0);
        check_eq("wr_nrsp", {7'd0, Rsp_Valid}, 8'd0);
        tick();
        check_eq("wr_sel_off", {4'd0, Write_Select}, 8'd0);
        check_eq("wr_ready2", {7'd0, Cmd_Ready}, 8'd1);
    endtask

    // hold = number of RESP cycles with Rsp_Ready low (0 means ready held high)
    task automatic do_read(input logic [1:0] r1, input logic [1:0] r2,
                           input logic [1:0] e1, input logic [1:0] e2, input int hold);
        Rsp_Ready = (hold == 0);
        Cmd_Valid = 1'b1; Cmd_Write = 1'b0; Cmd_Raddr1 = r1; Cmd_Raddr2 = r2;
        check_eq("rd_ready", {7'd0, Cmd_Ready}, 8'd1);
        tick();
        Cmd_Valid = 1'b0; Cmd_Raddr1 = ~r1; Cmd_Raddr2 = ~r2;
        check_eq("rd_sel1", {4'd0, Read_Select_1}, {4'd0, onehot(r1)});
        check_eq("rd_sel2", {4'd0, Read_Select_2}, {4'd0, onehot(r2)});
        check_eq("rd_early", {7'd0, Rsp_Valid}, 8'd0);
        tick();
        check_eq("rsp_valid", {7'd0, Rsp_Valid}, 8'd1);
        check_eq("rsp_d1", {6'd0, Rsp_Data1}, {6'd0, e1});
        check_eq("rsp_d2", {6'd0, Rsp_Data2}, {6'd0, e2});
        check_eq("rsp_sel_off", {Read_Select_1, Read_Select_2}, 8'd0);
        for (int i = 1; i < hold; i++) begin
            tick();
            check_eq("hold_valid", {7'd0, Rsp_Valid}, 8'd1);
            check_eq("hold_data", {4'd0, Rsp_Data1, Rsp_Data2}, {4'd0, e1, e2});
            check_eq("hold_busy", {7'd0, Cmd_Ready}, 8'd0);
        end
        Rsp_Ready = 1'b1;
        tick();
        Rsp_Ready = 1'b0;
        check_eq("rsp_done", {7'd0, Rsp_Valid}, 8'd0);
        check_eq("rsp_idle", {7'd0, Cmd_Ready}, 8'd1);
        check_eq("rsp_kept", {4'd0, Rsp_Data1, Rsp_Data2}, {4'd0, e1, e2});
    endtask

    initial begin
        reset = 1'b1; Cmd_Valid = 1'b0; Cmd_Write = 1'b0; Cmd_Waddr = 2'b00;
        Cmd_Wdata = 2'b00; Cmd_Raddr1 = 2'b00; Cmd_Raddr2 = 2'b00; Rsp_Ready = 1'b0;
        tick(); tick();
        check_eq("rst_ready", {7'd0, Cmd_Ready}, 8'd0);
        check_eq("rst_sels", {Write_Select, Read_Select_1 | Read_Select_2}, 8'd0);
        check_eq("rst_rsp", {3'd0, Rsp_Valid, Rsp_Data1, Rsp_Data2}, 8'd0);
        check_eq("rst_wdata", {6'd0, Write_Data}, 8'd0);
        reset = 1'b0;
        #1;
        check_eq("rst_release_ready", {7'd0, Cmd_Ready}, 8'd1);

        do_write(2'd2, 2'b10);
        do_write(2'd1, 2'b01);
        do_write(2'd3, 2'b11);
        do_read(2'd1, 2'd3, 2'b01, 2'b11, 0);
        do_write(2'd0, 2'b11);
        do_read(2'd0, 2'd0, 2'b11, 2'b11, 0);
        do_read(2'd2, 2'd1, 2'b10, 2'b01, 5);
        do_write(2'd0, 2'b01);
        do_read(2'd0, 2'd0, 2'b01, 2'b01, 0);

        // Reset while the response is held: it must vanish without a handshake
        Rsp_Ready = 1'b0;
        Cmd_Valid = 1'b1; Cmd_Write = 1'b0; Cmd_Raddr1 = 2'd3; Cmd_Raddr2 = 2'd2;
        tick();
        Cmd_Valid = 1'b0;
        tick();
        check_eq("pre_rst_valid", {7'd0, Rsp_Valid}, 8'd1);
        Rsp_Ready = 1'b1;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", {7'd0, Rsp_Valid}, 8'd0);
        check_eq("mid_rst_sels", {Write_Select, Read_Select_1 | Read_Select_2}, 8'd0);
        check_eq("mid_rst_data", {4'd0, Rsp_Data1, Rsp_Data2}, 8'd0);
        check_eq("mid_rst_ready", {7'd0, Cmd_Ready}, 8'd0);
        tick();
        check_eq("rst_no_pulse", {7'd0, Rsp_Valid}, 8'd0);
        reset = 1'b0;
        Rsp_Ready = 1'b0;
        #1;
        check_eq("rst2_ready", {7'd0, Cmd_Ready}, 8'd1);
        do_read(2'd2, 2'd3, 2'b10, 2'b11, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-003 SHALL have port Cmd_Valid, input, 1 bit; a command is presented.
REQ-004 SHALL have port Cmd_Ready, output, 1 bit; the controller accepts a command this cycle.
REQ-005 SHALL have port Cmd_Write, input, 1 bit; 1 = write command, 0 = dual read command.
REQ-006 SHALL have port Cmd_Waddr, input, 2 bits; write row address.
REQ-007 SHALL have port Cmd_Wdata, input, 2 bits; write data.
REQ-008 SHALL have ports Cmd_Raddr1 and Cmd_Raddr2, input, 2 bits each; read port 1 and read port 2 row addresses.
REQ-009 SHALL have port Write_Select, output, 4 bits; one-hot per-row write strobe to the 4x2-bit bank.
REQ-010 SHALL have port Write_Data, output, 2 bits; data driven to all rows.
REQ-011 SHALL have ports Read_Select_1 and Read_Select_2, output, 4 bits each; one-hot per-row read enables.
REQ-012 SHALL have ports Read_Data_1 and Read_Data_2, input, 2 bits each; bank read buses, where unselected rows contribute 0.
REQ-013 SHALL have port Rsp_Valid, output, 1 bit; read response held.
REQ-014 SHALL have port Rsp_Ready, input, 1 bit; consumer takes the response.
REQ-015 SHALL have ports Rsp_Data1 and Rsp_Data2, output, 2 bits each; captured read data.

Function
REQ-016 SHALL implement the FSM states IDLE, WRITE, READ and RESP.
REQ-017 SHALL drive Cmd_Ready=1 only in IDLE; a command is accepted on a clock edge where Cmd_Valid & Cmd_Ready.
REQ-018 SHALL register Cmd_Waddr, Cmd_Wdata, Cmd_Raddr1 and Cmd_Raddr2 on acceptance; after that, input changes have no effect until the next acceptance.
REQ-019 SHALL transition IDLE->WRITE on an accepted write and IDLE->READ on an accepted read; with no acceptance, it stays in IDLE.
REQ-020 SHALL, in WRITE, assert Write_Select equal to the one-hot of the latched Waddr for exactly one cycle, with Write_Data equal to the latched Wdata; it SHALL then go WRITE->IDLE unconditionally.
REQ-021 SHALL produce no response for a write command.
REQ-022 SHALL, in READ, assert Read_Select_1 and Read_Select_2 equal to the one-hot of the latched Raddr1/Raddr2 for exactly one cycle; it SHALL capture Read_Data_1/2 into Rsp_Data1/2 at the end of that cycle and go READ->RESP.
REQ-023 SHALL permit Raddr1 == Raddr2; both ports then return the same row value.
REQ-024 SHALL hold Rsp_Valid=1 in RESP with Rsp_Data1/2 stable; on a clock edge with Rsp_Ready=1 it SHALL go RESP->IDLE and Rsp_Valid SHALL fall.
REQ-025 SHALL give read latency as: Rsp_Valid high 2 cycles after the acceptance edge; Cmd_Ready high again on the cycle after the response handshake.
REQ-026 SHALL give write throughput as one write per 2 cycles; for a read-after-write to the same row, the read SHALL return the new data.
REQ-027 SHALL, when Rsp_Ready is held 1 before RESP is entered, complete the handshake on the first RESP cycle.
REQ-028 SHALL drive Write_Select, Read_Select_1 and Read_Select_2 to 0 in every state other than their own.
REQ-029 SHALL hold Rsp_Data1/2 at their last captured value outside RESP.

Reset
REQ-030 SHALL, on reset assertion, immediately (asynchronously) force state=IDLE, Write_Select=0, Read_Select_1=0, Read_Select_2=0, Write_Data=0, Rsp_Valid=0 and Rsp_Data1/2=0.
REQ-031 SHALL have Cmd_Ready=0 while reset is high and Cmd_Ready=1 on the first cycle after deassertion.
REQ-032 SHALL, on reset during WRITE, abandon the strobe; bank contents are then undefined per the bank's own reset.
REQ-033 SHALL, on reset during READ or RESP, discard the response with no Rsp_Valid pulse.

Structure
REQ-034 SHALL take from the shared package regfile_pkg: the state encoding, ADDR_W=2, DATA_W=2 and DEPTH=4.
REQ-035 SHALL use one sub-module, addr_decoder_2to4 (combinational 2-bit->4-bit one-hot with enable), instantiated three times.

Verification
REQ-036 SHALL cover this scenario: reset, then write addr 2 data 2'b10 -> Write_Select=4'b0100 for exactly one cycle with Write_Data=2'b10, and Cmd_Ready low for 1 cycle.
REQ-037 SHALL cover this scenario: write addr 1 data 2'b01, write addr 3 data 2'b11, then read raddr1=1, raddr2=3 -> Read_Select_1=4'b0010, Read_Select_2=4'b1000, Rsp_Data1=2'b01, Rsp_Data2=2'b11, Rsp_Valid 2 cycles after acceptance.
REQ-038 SHALL cover this scenario: read with Rsp_Ready=0 for 5 cycles -> Rsp_Valid and data stable, Cmd_Ready=0 throughout; raise Rsp_Ready -> IDLE next cycle.
REQ-039 SHALL cover this scenario: read raddr1=raddr2=0 after writing 2'b11 to row 0 -> both responses equal 2'b11.
REQ-040 SHALL cover this scenario: assert reset in RESP -> Rsp_Valid=0 and all selects=0 in the same cycle, with no handshake completing.
REQ-041 SHALL cover this scenario: back-to-back write to addr 0 then read of addr 0 -> the read returns the new data.
